// File: rtl/scie_fir_multich.sv
// scie_fir_multich: multi-channel FIR custom-instruction unit for the Rocket
// custom-instruction path. One shared coefficient bank and NCH delay lines.
// A single multiplier is time-shared across taps, one tap per cycle.
module scie_fir_multich #(
    parameter int XLEN  = 32,
    parameter int NTAPS = 5,
    parameter int NCH   = 4,
    parameter int ACC_W = 2*XLEN + $clog2(NTAPS)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            io_valid,
    input  logic [31:0]     io_insn,
    input  logic [XLEN-1:0] io_rs1,
    input  logic [XLEN-1:0] io_rs2,
    output logic            io_ready,
    output logic [XLEN-1:0] io_rd,
    output logic            io_busy
);

    localparam int SH_W = $clog2(ACC_W);
    localparam int K_W  = $clog2(NTAPS);
    localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

    localparam logic [6:0] OP_CFG   = 7'h0B;
    localparam logic [6:0] OP_PUSH  = 7'h2B;
    localparam logic [6:0] OP_READ  = 7'h5B;
    localparam logic [6:0] OP_CLEAR = 7'h7B;

    localparam logic [2:0] F3_SETCOEF = 3'd0;
    localparam logic [2:0] F3_CONFIG  = 3'd1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_WRITE
    } state_t;

    state_t state;
    state_t next_state;

    // Architectural state
    logic [XLEN-1:0]  coef   [NTAPS];
    logic [XLEN-1:0]  line   [NCH][NTAPS];
    logic [XLEN-1:0]  result [NCH];
    logic [SH_W-1:0]  shift_amt;
    logic             sat_en;

    // MAC datapath state
    logic [ACC_W-1:0] acc;
    logic [K_W-1:0]   k;
    logic [CH_W-1:0]  ch_sel;

    // Decode
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic             accept;
    logic             tap_ok;
    logic             ch_ok;
    logic             do_setcoef;
    logic             do_config;
    logic             do_push;
    logic             do_read;
    logic             do_clear;
    logic [K_W-1:0]   tap_idx;
    logic [CH_W-1:0]  ch_idx;
    logic             last_tap;

    // Datapath combinational values
    logic [XLEN-1:0]   coef_k;
    logic [XLEN-1:0]   samp_k;
    logic [2*XLEN-1:0] prod;
    logic [ACC_W-1:0]  acc_sum;
    logic [ACC_W-1:0]  shifted;
    logic [XLEN-1:0]   wb_val;
    logic [XLEN-1:0]   read_val;

    logic              unused_insn_bits;

    assign unused_insn_bits = ^{io_insn[31:15], io_insn[11:7]};

    assign opcode  = io_insn[6:0];
    assign funct3  = io_insn[14:12];
    assign io_ready = !io_busy;
    assign accept  = io_valid && io_ready;

    assign tap_ok  = (io_rs2 < XLEN'(NTAPS));
    assign ch_ok   = (io_rs2 < XLEN'(NCH));
    assign tap_idx = io_rs2[K_W-1:0];
    assign ch_idx  = io_rs2[CH_W-1:0];
    assign last_tap = (k == K_W'(NTAPS - 1));

    // Instruction decode; unknown encodings fall through with no effect
    always_comb begin
        do_setcoef = 1'b0;
        do_config  = 1'b0;
        do_push    = 1'b0;
        do_read    = 1'b0;
        do_clear   = 1'b0;
        if (accept) begin
            case (opcode)
                OP_CFG: begin
                    do_setcoef = (funct3 == F3_SETCOEF) && tap_ok;
                    do_config  = (funct3 == F3_CONFIG);
                end
                OP_PUSH:  do_push  = ch_ok;
                OP_READ:  do_read  = 1'b1;
                OP_CLEAR: do_clear = 1'b1;
                default:  ;
            endcase
        end
    end

    // MAC state register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // MAC next-state and busy output
    always_comb begin
        next_state = state;
        io_busy    = 1'b0;
        case (state)
            S_IDLE: begin
                if (do_push) begin
                    next_state = S_RUN;
                end
            end
            S_RUN: begin
                io_busy = 1'b1;
                if (last_tap) begin
                    next_state = S_WRITE;
                end
            end
            S_WRITE: begin
                io_busy    = 1'b1;
                next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Tap product, accumulation, and result formatting (shift then saturate or truncate)
    always_comb begin
        coef_k  = coef[k];
        samp_k  = line[ch_sel][k];
        prod    = (2*XLEN)'(coef_k) * (2*XLEN)'(samp_k);
        acc_sum = acc + ACC_W'(prod);
        shifted = acc >> shift_amt;
        if (sat_en && (|shifted[ACC_W-1:XLEN])) begin
            wb_val = '1;
        end else begin
            wb_val = shifted[XLEN-1:0];
        end
        read_val = ch_ok ? result[ch_idx] : '0;
    end

    // Architectural state, MAC datapath and result register updates
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned t = 0; t < NTAPS; t++) begin
                coef[t] <= '0;
            end
            for (int unsigned c = 0; c < NCH; c++) begin
                result[c] <= '0;
                for (int unsigned t = 0; t < NTAPS; t++) begin
                    line[c][t] <= '0;
                end
            end
            shift_amt <= '0;
            sat_en    <= 1'b0;
            acc       <= '0;
            k         <= '0;
            ch_sel    <= '0;
            io_rd     <= '0;
        end else begin
            if (do_setcoef) begin
                coef[tap_idx] <= io_rs1;
            end
            if (do_config) begin
                shift_amt <= io_rs1[SH_W-1:0];
                sat_en    <= io_rs1[8];
            end
            if (do_clear) begin
                for (int unsigned c = 0; c < NCH; c++) begin
                    result[c] <= '0;
                    for (int unsigned t = 0; t < NTAPS; t++) begin
                        line[c][t] <= '0;
                    end
                end
            end
            if (do_push) begin
                line[ch_idx][0] <= io_rs1;
                for (int unsigned t = 1; t < NTAPS; t++) begin
                    line[ch_idx][t] <= line[ch_idx][t-1];
                end
                acc    <= '0;
                k      <= '0;
                ch_sel <= ch_idx;
            end
            if (state == S_RUN) begin
                acc <= acc_sum;
                if (!last_tap) begin
                    k <= k + 1'b1;
                end
            end
            if (state == S_WRITE) begin
                result[ch_sel] <= wb_val;
            end
            if (do_read) begin
                io_rd <= read_val;
            end
        end
    end

endmodule
